// File: rtl/shift_sched_if.sv
// Request/grant/result bundle between the two requesters (A, B) and shift_sched.
// The master side drives requests; the slave side (the scheduler) returns grants and results.
interface shift_sched_if;
  logic        a_req;
  logic [2:0]  a_op;
  logic [4:0]  a_amt;
  logic [15:0] a_data;
  logic        a_gnt;
  logic        a_vld;

  logic        b_req;
  logic [2:0]  b_op;
  logic [4:0]  b_amt;
  logic [15:0] b_data;
  logic        b_gnt;
  logic        b_vld;

  logic [15:0] result;
  logic        err;
  logic        busy;

  modport master (
    output a_req, a_op, a_amt, a_data,
    output b_req, b_op, b_amt, b_data,
    input  a_gnt, a_vld, b_gnt, b_vld,
    input  result, err, busy
  );

  modport slave (
    input  a_req, a_op, a_amt, a_data,
    input  b_req, b_op, b_amt, b_data,
    output a_gnt, a_vld, b_gnt, b_vld,
    output result, err, busy
  );
endinterface

// File: rtl/shift_sched.sv
// Two-requester scheduler around one 16-bit logical barrel shifter; rotates use two passes.
// Optional arithmetic shift right (op 100) is enabled by defining SHIFT_SCHED_ASR_EN.
module shift_sched #(
  parameter bit RR_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  shift_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_P1   = 2'd1;
  localparam logic [1:0] ST_P2   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
`ifdef SHIFT_SCHED_ASR_EN
  localparam logic [2:0] OP_ASR = 3'b100;
`endif

  logic [1:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  amt_q, amt_d;
  logic [15:0] data_q, data_d;
  logic [15:0] tmp_q, tmp_d;
  logic        err_l_q, err_l_d;
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        a_vld_q, a_vld_d, b_vld_q, b_vld_d;

  logic        grant_a, grant_b;
  logic [3:0]  rot_n;
  logic [4:0]  rot_back;
  logic [15:0] sh_data;
  logic [15:0] sh_amt;
  logic        sh_left;
  logic [15:0] sh_out;

  assign rot_n    = amt_q[3:0];
  assign rot_back = 5'd16 - {1'b0, rot_n};

  // Shared shifter: amounts of 16 or more flush to zero.
  always_comb begin
    sh_out = '0;
    if (sh_amt[15:4] == 12'd0) begin
      sh_out = sh_left ? (sh_data << sh_amt[3:0]) : (sh_data >> sh_amt[3:0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    amt_d    = amt_q;
    data_d   = data_q;
    tmp_d    = tmp_q;
    err_l_d  = err_l_q;
    result_d = result_q;
    err_d    = err_q;
    a_gnt_d  = 1'b0;
    b_gnt_d  = 1'b0;
    a_vld_d  = 1'b0;
    b_vld_d  = 1'b0;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    sh_data  = '0;
    sh_amt   = '0;
    sh_left  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The vld cycle is kept free of grants so back-to-back service leaves a gap.
        if (!a_vld_q && !b_vld_q) begin
          if (bus.a_req && bus.b_req) begin
            grant_a = !rr_q;
            grant_b = rr_q;
            rr_d    = !rr_q;
          end else begin
            grant_a = bus.a_req;
            grant_b = bus.b_req;
          end
          if (grant_a || grant_b) begin
            owner_d = grant_b;
            op_d    = grant_b ? bus.b_op   : bus.a_op;
            amt_d   = grant_b ? bus.b_amt  : bus.a_amt;
            data_d  = grant_b ? bus.b_data : bus.a_data;
            tmp_d   = '0;
            err_l_d = 1'b0;
            a_gnt_d = grant_a;
            b_gnt_d = grant_b;
            state_d = ST_P1;
          end
        end
      end

      ST_P1: begin
        case (op_q)
          OP_SLL, OP_SRL: begin
            sh_data = data_q;
            sh_amt  = {12'd0, rot_n};
            sh_left = (op_q == OP_SLL);
            tmp_d   = amt_q[4] ? 16'd0 : sh_out;
            state_d = ST_DONE;
          end
          OP_ROL, OP_ROR: begin
            sh_data = data_q;
            sh_amt  = {12'd0, rot_n};
            sh_left = (op_q == OP_ROL);
            tmp_d   = sh_out;
            state_d = (rot_n == 4'd0) ? ST_DONE : ST_P2;
          end
`ifdef SHIFT_SCHED_ASR_EN
          OP_ASR: begin
            sh_data = data_q;
            sh_amt  = {12'd0, rot_n};
            sh_left = 1'b0;
            tmp_d   = amt_q[4] ? {16{data_q[15]}} : sh_out;
            state_d = (data_q[15] && rot_n != 4'd0) ? ST_P2 : ST_DONE;
          end
`endif
          default: begin
            tmp_d   = data_q;
            err_l_d = 1'b1;
            state_d = ST_DONE;
          end
        endcase
      end

      ST_P2: begin
        // Second pass supplies the bits that wrapped around (or the sign fill for ASR).
        sh_amt  = {11'd0, rot_back};
`ifdef SHIFT_SCHED_ASR_EN
        if (op_q == OP_ASR) begin
          sh_data = 16'hFFFF;
          sh_left = 1'b1;
        end else begin
          sh_data = data_q;
          sh_left = (op_q != OP_ROL);
        end
`else
        sh_data = data_q;
        sh_left = (op_q != OP_ROL);
`endif
        tmp_d   = tmp_q | sh_out;
        state_d = ST_DONE;
      end

      default: begin
        result_d = tmp_q;
        err_d    = err_l_q;
        a_vld_d  = !owner_q;
        b_vld_d  = owner_q;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_q     <= RR_INIT;
      owner_q  <= 1'b0;
      op_q     <= '0;
      amt_q    <= '0;
      data_q   <= '0;
      tmp_q    <= '0;
      err_l_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      amt_q    <= amt_d;
      data_q   <= data_d;
      tmp_q    <= tmp_d;
      err_l_q  <= err_l_d;
      result_q <= result_d;
      err_q    <= err_d;
      a_gnt_q  <= a_gnt_d;
      b_gnt_q  <= b_gnt_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
    end
  end

  assign bus.a_gnt  = a_gnt_q;
  assign bus.b_gnt  = b_gnt_q;
  assign bus.a_vld  = a_vld_q;
  assign bus.b_vld  = b_vld_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != ST_IDLE);

endmodule
